// File: rtl/rmii_rx_frame_if.sv
// Byte stream from the RMII/MII nibble-to-byte receiver into the frame parser, and
// the qualified frame stream plus per-frame status out to the MAC packet writer.
interface rmii_rx_frame_if;
  logic        rx_dv;
  logic        rx_er;
  logic        rx_byte_vld;
  logic [7:0]  rx_byte;

  logic [7:0]  m_data;
  logic        m_vld;
  logic        m_sof;
  logic        m_eof;
  logic [10:0] m_len;
  logic        m_addr_ok;
  logic        m_len_ok;
  logic        m_fcs_ok;
  logic        m_err;
  logic        m_good;

  // The parser is the source of the frame stream.
  modport master (
    input  rx_dv, rx_er, rx_byte_vld, rx_byte,
    output m_data, m_vld, m_sof, m_eof, m_len,
           m_addr_ok, m_len_ok, m_fcs_ok, m_err, m_good
  );

  modport slave (
    output rx_dv, rx_er, rx_byte_vld, rx_byte,
    input  m_data, m_vld, m_sof, m_eof, m_len,
           m_addr_ok, m_len_ok, m_fcs_ok, m_err, m_good
  );
endinterface

// File: rtl/rmii_rx_frame.sv
// Receive frame parser: strips preamble/SFD, streams dest..FCS bytes, reports per-frame status.
// Define RMII_RX_FCS_CHK_EN to build the CRC-32 FCS checker; otherwise m_fcs_ok is always 1.
module rmii_rx_frame #(
  parameter logic [47:0] P_MAC_ADDR = 48'h0000_0000_0000,
  parameter int          P_MIN_LEN  = 64,
  parameter int          P_MAX_LEN  = 1518
) (
  input  logic            rx_clk,
  input  logic            rx_rst_n,
  rmii_rx_frame_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_EOF,
    S_DROP
  } state_t;

  localparam logic [10:0] MIN_LEN  = 11'(P_MIN_LEN);
  localparam logic [10:0] MAX_LEN  = 11'(P_MAX_LEN);
  localparam logic [10:0] LEN_SAT  = 11'h7FF;
  localparam logic [10:0] ADDR_LEN = 11'd6;
  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;

  function automatic logic [7:0] mac_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    mac_byte = P_MAC_ADDR[47:40];
      3'd1:    mac_byte = P_MAC_ADDR[39:32];
      3'd2:    mac_byte = P_MAC_ADDR[31:24];
      3'd3:    mac_byte = P_MAC_ADDR[23:16];
      3'd4:    mac_byte = P_MAC_ADDR[15:8];
      3'd5:    mac_byte = P_MAC_ADDR[7:0];
      default: mac_byte = 8'h00;
    endcase
  endfunction

  state_t      state, state_nxt;
  logic        rx_dv_q;
  logic [2:0]  pre_cnt;
  logic [10:0] byte_cnt;
  logic        uc_match;
  logic        bc_match;
  logic        err_acc;
  logic        eof_c;

  logic qual, dv_rise, pre_hit, sfd_hit, frame_end;
  logic addr_ok_c, len_ok_c, fcs_ok_c, err_c;

  assign qual      = bus.rx_byte_vld & bus.rx_dv;
  assign dv_rise   = bus.rx_dv & ~rx_dv_q;
  assign pre_hit   = (state == S_PRE) && qual && (bus.rx_byte == PRE_BYTE);
  assign sfd_hit   = (state == S_PRE) && qual && (bus.rx_byte == SFD_BYTE);
  assign frame_end = (state == S_DATA) && !bus.rx_dv;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_nxt = state;
    eof_c     = 1'b0;
    case (state)
      S_IDLE: begin
        // Only a fresh rx_dv rise starts a frame, so we never join one mid-stream.
        if (dv_rise) state_nxt = S_PRE;
      end
      S_PRE: begin
        if (!bus.rx_dv)                      state_nxt = S_IDLE;
        else if (sfd_hit)                    state_nxt = S_DATA;
        else if (pre_hit && pre_cnt != 3'd7) state_nxt = S_PRE;
        else if (qual)                       state_nxt = S_DROP;
      end
      S_DATA: begin
        if (!bus.rx_dv) state_nxt = S_EOF;
      end
      S_EOF: begin
        eof_c     = 1'b1;
        state_nxt = dv_rise ? S_PRE : S_IDLE;
      end
      S_DROP: begin
        if (!bus.rx_dv) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.m_eof = eof_c;

  // Counts 0x55 bytes accepted so far; an 8th one overflows into DROP above.
  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n)            pre_cnt <= 3'd0;
    else if (state != S_PRE)  pre_cnt <= 3'd0;
    else if (pre_hit)         pre_cnt <= pre_cnt + 3'd1;
  end

  // ---------------------------------------------------------------------------
  // FCS residue check
  // ---------------------------------------------------------------------------
`ifdef RMII_RX_FCS_CHK_EN
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  logic [31:0] crc_reg;

  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n)                    crc_reg <= '1;
    else if (sfd_hit)                 crc_reg <= '1;
    else if (state == S_DATA && qual) crc_reg <= crc_step(crc_reg, bus.rx_byte);
  end

  // Running the CRC across the received FCS leaves a fixed residue on a clean frame.
  assign fcs_ok_c = (crc_reg == CRC_RESIDUE);
`else
  assign fcs_ok_c = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Byte stream, accumulators and status
  // ---------------------------------------------------------------------------
  assign addr_ok_c = (byte_cnt >= ADDR_LEN) && (uc_match || bc_match);
  assign len_ok_c  = (byte_cnt >= MIN_LEN) && (byte_cnt <= MAX_LEN);
  assign err_c     = err_acc | bus.rx_er;

  always_ff @(posedge rx_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // in this block sees the pre-edge value of its neighbours.
    if (!rx_rst_n) begin
      rx_dv_q       <= 1'b1;
      byte_cnt      <= '0;
      uc_match      <= 1'b0;
      bc_match      <= 1'b0;
      err_acc       <= 1'b0;
      bus.m_data    <= '0;
      bus.m_vld     <= 1'b0;
      bus.m_sof     <= 1'b0;
      bus.m_len     <= '0;
      bus.m_addr_ok <= 1'b0;
      bus.m_len_ok  <= 1'b0;
      bus.m_fcs_ok  <= 1'b0;
      bus.m_err     <= 1'b0;
      bus.m_good    <= 1'b0;
    end else begin
      rx_dv_q   <= bus.rx_dv;
      bus.m_vld <= 1'b0;
      bus.m_sof <= 1'b0;

      if (sfd_hit) begin
        byte_cnt <= '0;
        uc_match <= 1'b1;
        bc_match <= 1'b1;
        err_acc  <= 1'b0;
      end

      if (state == S_DATA) begin
        if (bus.rx_er) err_acc <= 1'b1;

        if (qual) begin
          bus.m_data <= bus.rx_byte;
          // Oversize tail is still counted and CRC'd but never forwarded.
          bus.m_vld  <= (byte_cnt < MAX_LEN);
          bus.m_sof  <= (byte_cnt == '0);

          if (byte_cnt == '0) begin
            bus.m_len     <= '0;
            bus.m_addr_ok <= 1'b0;
            bus.m_len_ok  <= 1'b0;
            bus.m_fcs_ok  <= 1'b0;
            bus.m_err     <= 1'b0;
            bus.m_good    <= 1'b0;
          end

          if (byte_cnt < ADDR_LEN) begin
            if (bus.rx_byte != mac_byte(byte_cnt[2:0])) uc_match <= 1'b0;
            if (bus.rx_byte != 8'hFF)                   bc_match <= 1'b0;
          end

          if (byte_cnt != LEN_SAT) byte_cnt <= byte_cnt + 11'd1;
        end

        // Status lands on the same edge that enters EOF, so it is valid with m_eof.
        if (frame_end) begin
          bus.m_len     <= byte_cnt;
          bus.m_addr_ok <= addr_ok_c;
          bus.m_len_ok  <= len_ok_c;
          bus.m_fcs_ok  <= fcs_ok_c;
          bus.m_err     <= err_c;
          bus.m_good    <= addr_ok_c & len_ok_c & fcs_ok_c & ~err_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_rmii_rx_frame.sv
// Self-checking bench for rmii_rx_frame: directed and randomized frames scored against
// a frame-level reference model (expected byte stream, SOF positions and EOF status).
module tb_rmii_rx_frame;

  localparam logic [47:0] MAC     = 48'h02_1A_2B_3C_4D_5E;
  localparam int          MIN_LEN = 64;
  localparam int          MAX_LEN = 1518;

  typedef struct packed {
    logic [10:0] len;
    logic        addr_ok;
    logic        len_ok;
    logic        fcs_ok;
    logic        err;
    logic        good;
  } stat_t;

  logic rx_clk = 1'b0;
  logic rx_rst_n = 1'b0;
  always #5 rx_clk = ~rx_clk;

  rmii_rx_frame_if bus ();

  rmii_rx_frame #(
    .P_MAC_ADDR(MAC),
    .P_MIN_LEN (MIN_LEN),
    .P_MAX_LEN (MAX_LEN)
  ) dut (
    .rx_clk  (rx_clk),
    .rx_rst_n(rx_rst_n),
    .bus     (bus)
  );

  int nchk = 0;
  int npass = 0;

  logic [7:0] tx_q[$];
  logic [7:0] pre_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         got_sof[$];
  int         exp_sof[$];
  stat_t      got_st[$];
  stat_t      exp_st[$];
  int         sof_stat_bad = 0;

  function automatic stat_t cur_stat();
    stat_t s;
    s.len     = bus.m_len;
    s.addr_ok = bus.m_addr_ok;
    s.len_ok  = bus.m_len_ok;
    s.fcs_ok  = bus.m_fcs_ok;
    s.err     = bus.m_err;
    s.good    = bus.m_good;
    return s;
  endfunction

  // Monitor: outputs sampled on the falling edge, away from the active edge.
  always @(negedge rx_clk) begin
    if (bus.m_vld) begin
      if (bus.m_sof) begin
        got_sof.push_back(got_q.size());
        if (cur_stat() != '0) sof_stat_bad++;
      end
      got_q.push_back(bus.m_data);
    end
    if (bus.m_eof) got_st.push_back(cur_stat());
  end

  // ---------------------------------------------------------------------------
  // Frame construction and reference model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] fcs_of(input int m);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < m; i++) begin
      c = c ^ {24'h0, tx_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input logic [47:0] dest, input int plen);
    logic [31:0] f;
    tx_q.delete();
    for (int i = 0; i < 6; i++) tx_q.push_back(dest[40-8*i +: 8]);
    for (int i = 0; i < 6; i++) tx_q.push_back(8'($urandom));
    tx_q.push_back(8'h08);
    tx_q.push_back(8'h00);
    for (int i = 0; i < plen; i++) tx_q.push_back(8'($urandom));
    f = fcs_of(tx_q.size());
    tx_q.push_back(f[7:0]);
    tx_q.push_back(f[15:8]);
    tx_q.push_back(f[23:16]);
    tx_q.push_back(f[31:24]);
  endtask

  task automatic set_pre(input int n55);
    pre_q.delete();
    for (int i = 0; i < n55; i++) pre_q.push_back(8'h55);
    pre_q.push_back(8'hD5);
  endtask

  // Expected results for tx_q as a frame that the parser accepts.
  task automatic model_frame(input bit er);
    int          n;
    int          nout;
    bit          uc;
    bit          bc;
    stat_t       s;
    logic [47:0] mac_v;
    mac_v = MAC;
    n     = tx_q.size();
    nout  = (n < MAX_LEN) ? n : MAX_LEN;
    if (nout > 0) exp_sof.push_back(exp_q.size());
    for (int i = 0; i < nout; i++) exp_q.push_back(tx_q[i]);
    uc = (n >= 6);
    bc = (n >= 6);
    for (int i = 0; i < 6 && i < n; i++) begin
      if (tx_q[i] != mac_v[40-8*i +: 8]) uc = 1'b0;
      if (tx_q[i] != 8'hFF)              bc = 1'b0;
    end
    s.len     = (n > 2047) ? 11'd2047 : 11'(n);
    s.addr_ok = uc | bc;
    s.len_ok  = (n >= MIN_LEN) && (n <= MAX_LEN);
`ifdef RMII_RX_FCS_CHK_EN
    s.fcs_ok  = (n >= 4) && ({tx_q[n-1], tx_q[n-2], tx_q[n-3], tx_q[n-4]} == fcs_of(n - 4));
`else
    s.fcs_ok  = 1'b1;
`endif
    s.err     = er;
    s.good    = s.addr_ok & s.len_ok & s.fcs_ok & ~er;
    exp_st.push_back(s);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic dv, input logic vld, input logic er, input logic [7:0] b);
    @(posedge rx_clk);
    #1;
    bus.rx_dv       = dv;
    bus.rx_byte_vld = vld;
    bus.rx_er       = er;
    bus.rx_byte     = b;
  endtask

  // Bytes arrive every other cycle, as from the nibble assembler; idle strobes carry junk.
  task automatic send_frame(input int er_idx, input int gap);
    cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
    foreach (pre_q[i]) begin
      cyc(1'b1, 1'b1, 1'b0, pre_q[i]);
      cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
    end
    foreach (tx_q[i]) begin
      cyc(1'b1, 1'b1, (i == er_idx), tx_q[i]);
      cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
    end
    for (int g = 0; g < gap; g++) cyc(1'b0, g[0], 1'b0, 8'($urandom));
  endtask

  task automatic idle(input int n);
    for (int g = 0; g < n; g++) cyc(1'b0, g[0], 1'b0, 8'($urandom));
  endtask

  task automatic clear_queues();
    got_q.delete();
    exp_q.delete();
    got_sof.delete();
    exp_sof.delete();
    got_st.delete();
    exp_st.delete();
    sof_stat_bad = 0;
  endtask

  // Compares everything collected since the last call against the model, then clears.
  task automatic score(input string name);
    bit    ok;
    int    bad;
    stat_t s;

    nchk++;
    bad = -1;
    ok  = (got_q.size() == exp_q.size());
    if (ok) foreach (exp_q[i]) if (got_q[i] !== exp_q[i] && bad < 0) bad = i;
    if (!ok)
      $display("FAIL %s byte_count got %0d expected %0d", name, got_q.size(), exp_q.size());
    else if (bad >= 0)
      $display("FAIL %s data[%0d] got %h expected %h", name, bad, got_q[bad], exp_q[bad]);
    else npass++;

    nchk++;
    ok = (got_sof.size() == exp_sof.size());
    if (ok) foreach (exp_sof[i]) if (got_sof[i] != exp_sof[i]) ok = 1'b0;
    if (ok) npass++;
    else $display("FAIL %s sof got %0d pulses expected %0d at byte positions", name,
                  got_sof.size(), exp_sof.size());

    nchk++;
    if (sof_stat_bad == 0) npass++;
    else $display("FAIL %s sof_status_clear got %0d nonzero expected 0", name, sof_stat_bad);

    nchk++;
    if (got_st.size() == exp_st.size()) begin
      npass++;
      foreach (exp_st[i]) begin
        nchk++;
        if (got_st[i] === exp_st[i]) npass++;
        else $display("FAIL %s eof[%0d] got len=%0d a/l/f/e/g=%b%b%b%b%b expected len=%0d a/l/f/e/g=%b%b%b%b%b",
                      name, i, got_st[i].len, got_st[i].addr_ok, got_st[i].len_ok, got_st[i].fcs_ok,
                      got_st[i].err, got_st[i].good, exp_st[i].len, exp_st[i].addr_ok,
                      exp_st[i].len_ok, exp_st[i].fcs_ok, exp_st[i].err, exp_st[i].good);
      end
    end else begin
      $display("FAIL %s eof_count got %0d expected %0d", name, got_st.size(), exp_st.size());
    end

    if (exp_st.size() > 0) begin
      @(negedge rx_clk);
      s = cur_stat();
      nchk++;
      if (s === exp_st[exp_st.size()-1]) npass++;
      else $display("FAIL %s held_status got %h expected %h", name, s, exp_st[exp_st.size()-1]);
    end
    clear_queues();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rx_rst_n = 1'b0;
    idle(4);
    @(negedge rx_clk);
    nchk++;
    if ({bus.m_vld, bus.m_sof, bus.m_eof, bus.m_data} === '0 && cur_stat() === '0) npass++;
    else $display("FAIL reset_outputs got vld/sof/eof=%b%b%b data=%h status=%h expected all 0",
                  bus.m_vld, bus.m_sof, bus.m_eof, bus.m_data, cur_stat());
    @(posedge rx_clk);
    #1;
    rx_rst_n = 1'b1;
    idle(4);
    clear_queues();
  endtask

  task automatic test_unicast();
    set_pre(7);
    build_frame(MAC, 46);
    model_frame(1'b0);
    send_frame(-1, 8);
    score("unicast_64");
  endtask

  task automatic test_addr();
    set_pre(7);
    build_frame(48'hFF_FF_FF_FF_FF_FF, 46);
    model_frame(1'b0);
    send_frame(-1, 8);
    score("broadcast");

    build_frame(48'h02_00_00_00_00_01, 46);
    model_frame(1'b0);
    send_frame(-1, 8);
    score("addr_mismatch");

    // Five bytes that match the station address so far still cannot pass.
    set_pre(3);
    tx_q.delete();
    for (int i = 0; i < 5; i++) tx_q.push_back(MAC[40-8*i +: 8]);
    model_frame(1'b0);
    send_frame(-1, 8);
    score("short_addr");
  endtask

  task automatic test_fcs();
    set_pre(7);
    build_frame(MAC, 46);
    tx_q[20] = tx_q[20] ^ 8'h10;
    model_frame(1'b0);
    send_frame(-1, 8);
    score("fcs_corrupt");
  endtask

  task automatic test_length();
    set_pre(7);
    build_frame(MAC, 22);
    model_frame(1'b0);
    send_frame(-1, 8);
    score("len_40");

    build_frame(MAC, 1582);
    model_frame(1'b0);
    send_frame(-1, 8);
    score("len_1600");

    build_frame(MAC, 2082);
    model_frame(1'b0);
    send_frame(-1, 8);
    score("len_2100_sat");
  endtask

  task automatic test_bad_preamble();
    build_frame(MAC, 46);
    pre_q.delete();
    pre_q.push_back(8'h55);
    pre_q.push_back(8'h55);
    pre_q.push_back(8'hAA);
    send_frame(-1, 6);

    set_pre(8);
    send_frame(-1, 6);

    set_pre(0);
    build_frame(MAC, 50);
    model_frame(1'b0);
    send_frame(-1, 8);
    score("bad_preamble");
  endtask

  task automatic test_rx_er();
    set_pre(7);
    build_frame(MAC, 46);
    model_frame(1'b1);
    send_frame(30, 8);
    score("rx_er");
  endtask

  task automatic test_reset_mid_frame();
    set_pre(7);
    build_frame(MAC, 46);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    foreach (pre_q[i]) begin
      cyc(1'b1, 1'b1, 1'b0, pre_q[i]);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 1'b0, tx_q[i]);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
    end
    rx_rst_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 8'h55);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'hD5);
    @(negedge rx_clk);
    nchk++;
    if ({bus.m_vld, bus.m_eof} === 2'b00 && cur_stat() === '0) npass++;
    else $display("FAIL reset_mid_outputs got vld/eof=%b%b status=%h expected 0",
                  bus.m_vld, bus.m_eof, cur_stat());
    clear_queues();
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    rx_rst_n = 1'b1;
    for (int i = 20; i < tx_q.size(); i++) begin
      cyc(1'b1, 1'b1, 1'b0, tx_q[i]);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
    end
    idle(8);
    score("reset_mid_abandon");

    build_frame(MAC, 46);
    model_frame(1'b0);
    send_frame(-1, 8);
    score("after_reset_mid");
  endtask

  task automatic test_back_to_back();
    set_pre(7);
    build_frame(48'hFF_FF_FF_FF_FF_FF, 50);
    model_frame(1'b0);
    send_frame(-1, 1);
    set_pre(5);
    build_frame(MAC, 46);
    model_frame(1'b0);
    send_frame(-1, 8);
    score("back_to_back");
  endtask

  task automatic test_random();
    logic [47:0] dest;
    int          sel;
    int          er_idx;
    for (int k = 0; k < 12; k++) begin
      sel = $urandom_range(0, 2);
      if (sel == 0)      dest = MAC;
      else if (sel == 1) dest = 48'hFF_FF_FF_FF_FF_FF;
      else               dest = {16'($urandom), 32'($urandom)};
      build_frame(dest, $urandom_range(0, 80));
      if ($urandom_range(0, 2) == 0)
        tx_q[$urandom_range(0, tx_q.size() - 1)] ^= (8'($urandom) | 8'h01);
      er_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, tx_q.size() - 1) : -1;
      set_pre($urandom_range(0, 7));
      model_frame(er_idx >= 0);
      send_frame(er_idx, $urandom_range(1, 6));
    end
    idle(8);
    score("random");
  endtask

  initial begin
    bus.rx_dv       = 1'b0;
    bus.rx_er       = 1'b0;
    bus.rx_byte_vld = 1'b0;
    bus.rx_byte     = 8'h00;
    test_reset();
    test_unicast();
    test_addr();
    test_fcs();
    test_length();
    test_bad_preamble();
    test_rx_er();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
